sreg_file: RTL and testbench
============================

# sreg_file

Special-register file that consumes the SREG write port of the writeback stage (`sreg_wr_en/group/regnum/plevel/val`) and serves a combinational read port to the execute stage. It holds privilege-banked special registers plus two free-running architectural counters (cycle, instructions retired). Writes commit at the clock edge. A same-cycle read of the address being written is bypassed.

## Interface
- `REG_WIDTH`, `core::REG_WIDTH`: width of every special register.
- `NUM_GROUPS`, 4: implemented groups 0..NUM_GROUPS-1; range 2..32.
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `cur_plevel`  in  2  current privilege level; 0 is most privileged.
- `retire_valid`  in  1  one instruction retired this cycle.
- `wr_en`  in  1  write request.
- `wr_group`  in  5  write group.
- `wr_regnum`  in  3  write register number.
- `wr_plevel`  in  2  write bank.
- `wr_val`  in  REG_WIDTH  write data.
- `rd_group`  in  5  read group.
- `rd_regnum`  in  3  read register number.
- `rd_plevel`  in  2  read bank.
- `rd_val`  out  REG_WIDTH  read data, combinational.
- `rd_fault`  out  1  read privilege violation, combinational.
- `wr_fault`  out  1  registered; pulses one cycle after a denied write.

## Operation
- Address space: group × regnum × plevel.
  - Groups 1..NUM_GROUPS-1: 8 regs × 4 plevel banks each, REG_WIDTH storage.
  - Group 0: unbanked, so plevel selects nothing there.
    - regnum 0 = CYCLE.
    - regnum 1 = INSTRET.
    - regnum 2..7 read 0; writes to them are dropped, no fault.
  - Groups ≥ NUM_GROUPS: read 0, writes dropped, no fault.
- Privilege check: an access is legal iff `plevel >= cur_plevel`.
  - Illegal write: storage unchanged; `wr_fault`=1 next cycle.
  - Illegal read: `rd_val`=0, `rd_fault`=1 in the same cycle.
  - The check applies to group 0 too, using the supplied `plevel`.
- CYCLE: +1 every non-reset cycle.
- INSTRET: +1 on each cycle with `retire_valid`=1.
- Counter arithmetic is modulo 2^REG_WIDTH; all-ones wraps to 0, with no flag.
- A legal write to a counter loads `wr_val` exactly. The increment in that cycle is discarded, and counting resumes from `wr_val` next cycle.
- Read bypass: if `wr_en` is legal and the write and read addresses match (plevel ignored in group 0), `rd_val`=`wr_val`. Otherwise `rd_val` is the stored value.
  - The bypass does not apply to counter increments; the read shows the pre-increment value.

## Timing
- Write latency 1: the value commits at the posedge where `wr_en`=1 and is visible via storage from the next cycle.
- Read latency 0: `rd_val` and `rd_fault` depend combinationally on read address, `cur_plevel` and the write port.
- `wr_fault` is registered and asserted for exactly one cycle per denied write. Back-to-back denied writes hold it high.
- Reset:
  - All storage, CYCLE, INSTRET and `wr_fault` become 0 at the first rising edge with `rst`=1.
  - Writes and `retire_valid` in reset cycles are ignored.
  - CYCLE reads 0 in the first cycle after reset deasserts and 1 in the next.
- Reset asserted mid-stream overrides any write or increment in that cycle.
- No handshake and no back-pressure: a write is accepted every cycle.

## Structure
- The `core` package gains:
  - `SREG_GROUP_W`=5, `SREG_REGNUM_W`=3, `SREG_PLEVEL_W`=2.
  - `SREG_GRP_CNT`=0, `SREG_CYCLE`=0, `SREG_INSTRET`=1.
  - A packed `SregAddr` struct {group, regnum, plevel}.
- One sub-module, `sreg_counter`:
  - A REG_WIDTH loadable wrapping counter with synchronous reset.
  - Ports: clk, rst, inc, load, load_val, count.
  - load has priority over inc.
  - Instantiated twice, for CYCLE and INSTRET.
- Banked storage is a flat array indexed by {group-1, regnum, plevel}.

## Test plan
- Bank isolation:
  - Stimulus: reset, then with `cur_plevel`=0 write 0xA5 to (1,3,2) and 0x5A to (1,3,1).
  - Required: next cycle, a read of (1,3,2) returns 0xA5, (1,3,1) returns 0x5A and (1,3,0) returns 0.
- Read bypass:
  - Stimulus: write 0x1234 to (2,7,0) while reading (2,7,0) in the same cycle.
  - Required: `rd_val`=0x1234 in that cycle.
- Privilege:
  - Stimulus: `cur_plevel`=2; write 0xFF to (1,0,1), then read (1,0,1).
  - Required: `wr_fault`=1 exactly one cycle later and the register stays 0; the read gives `rd_fault`=1, `rd_val`=0.
  - Stimulus: read (1,0,3).
  - Required: `rd_fault`=0.
- Counters:
  - Stimulus: after reset, hold `retire_valid`=1 for 3 of 5 cycles.
  - Required: reading group 0 gives CYCLE=5 and INSTRET=3.
  - Stimulus: write 0xFFFF…FF to CYCLE.
  - Required: CYCLE reads 0 two cycles later (all-ones, then wraps to 0).
- Counter load vs increment:
  - Stimulus: write 100 to INSTRET with `retire_valid`=1 in the same cycle.
  - Required: INSTRET reads 100 next cycle, not 101.
- Out-of-range and reset:
  - Stimulus: write to group NUM_GROUPS.
  - Required: no fault, and it reads 0.
  - Stimulus: assert `rst` during a write to (1,1,0).
  - Required: the register reads 0 after reset.

Source files
------------

// File: rtl/core.sv
// Core-wide constants and the special-register address types used by the
// SREG read/write ports.
package core;

    localparam int REG_WIDTH     = 32;
    localparam int SREG_GROUP_W  = 5;
    localparam int SREG_REGNUM_W = 3;
    localparam int SREG_PLEVEL_W = 2;

    localparam logic [SREG_GROUP_W-1:0]  SREG_GRP_CNT = 5'd0;
    localparam logic [SREG_REGNUM_W-1:0] SREG_CYCLE   = 3'd0;
    localparam logic [SREG_REGNUM_W-1:0] SREG_INSTRET = 3'd1;

    typedef struct packed {
        logic [SREG_GROUP_W-1:0]  group;
        logic [SREG_REGNUM_W-1:0] regnum;
        logic [SREG_PLEVEL_W-1:0] plevel;
    } SregAddr;

    typedef enum logic [1:0] {
        SREG_KIND_NONE,
        SREG_KIND_CYCLE,
        SREG_KIND_INSTRET,
        SREG_KIND_BANK
    } sreg_kind_e;

    // Classifies an address; NONE covers unimplemented group-0 slots and
    // groups beyond the implemented range.
    function automatic sreg_kind_e sreg_decode(input SregAddr a, input int num_groups);
        sreg_kind_e kind;
        kind = SREG_KIND_NONE;
        if (a.group == SREG_GRP_CNT) begin
            if (a.regnum == SREG_CYCLE)
                kind = SREG_KIND_CYCLE;
            else if (a.regnum == SREG_INSTRET)
                kind = SREG_KIND_INSTRET;
        end else if (int'(a.group) < num_groups) begin
            kind = SREG_KIND_BANK;
        end
        return kind;
    endfunction

endpackage

// File: rtl/sreg_counter.sv
// Loadable wrapping up-counter; a load in the same cycle as an increment wins.
module sreg_counter #(
    parameter int WIDTH = core::REG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (inc)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/sreg_file.sv
// Privilege-banked special-register file with CYCLE/INSTRET counters in
// group 0, a clocked write port and a combinational, write-bypassed read port.
module sreg_file #(
    parameter int REG_WIDTH  = core::REG_WIDTH,
    parameter int NUM_GROUPS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [core::SREG_PLEVEL_W-1:0] cur_plevel,
    input  logic                           retire_valid,
    input  logic                           wr_en,
    input  logic [core::SREG_GROUP_W-1:0]  wr_group,
    input  logic [core::SREG_REGNUM_W-1:0] wr_regnum,
    input  logic [core::SREG_PLEVEL_W-1:0] wr_plevel,
    input  logic [REG_WIDTH-1:0]           wr_val,
    input  logic [core::SREG_GROUP_W-1:0]  rd_group,
    input  logic [core::SREG_REGNUM_W-1:0] rd_regnum,
    input  logic [core::SREG_PLEVEL_W-1:0] rd_plevel,
    output logic [REG_WIDTH-1:0]           rd_val,
    output logic                           rd_fault,
    output logic                           wr_fault
);
    import core::*;

    localparam int BANK_DEPTH = (NUM_GROUPS - 1) * 32;
    localparam int BANK_AW    = $clog2(BANK_DEPTH);

    function automatic logic [BANK_AW-1:0] bank_idx(input SregAddr a);
        logic [SREG_GROUP_W+SREG_REGNUM_W+SREG_PLEVEL_W-1:0] flat;
        flat = {a.group - 5'd1, a.regnum, a.plevel};
        return flat[BANK_AW-1:0];
    endfunction

    SregAddr             wr_addr;
    SregAddr             rd_addr;
    sreg_kind_e          wr_kind;
    sreg_kind_e          rd_kind;
    logic [BANK_AW-1:0]  wr_idx;
    logic [BANK_AW-1:0]  rd_idx;
    logic                wr_in_space;
    logic                rd_in_space;
    logic                wr_legal;
    logic                rd_legal;
    logic                wr_commit;
    logic                bypass;
    logic [REG_WIDTH-1:0] rd_stored;
    logic [REG_WIDTH-1:0] cycle_count;
    logic [REG_WIDTH-1:0] instret_count;
    logic [REG_WIDTH-1:0] bank_mem [BANK_DEPTH];

    assign wr_addr = '{group: wr_group, regnum: wr_regnum, plevel: wr_plevel};
    assign rd_addr = '{group: rd_group, regnum: rd_regnum, plevel: rd_plevel};

    assign wr_kind = sreg_decode(wr_addr, NUM_GROUPS);
    assign rd_kind = sreg_decode(rd_addr, NUM_GROUPS);
    assign wr_idx  = bank_idx(wr_addr);
    assign rd_idx  = bank_idx(rd_addr);

    // Unimplemented groups silently ignore accesses, so they never fault.
    assign wr_in_space = int'(wr_group) < NUM_GROUPS;
    assign rd_in_space = int'(rd_group) < NUM_GROUPS;
    assign wr_legal    = wr_plevel >= cur_plevel;
    assign rd_legal    = rd_plevel >= cur_plevel;

    assign wr_commit = wr_en && wr_legal && (wr_kind != SREG_KIND_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BANK_DEPTH; i++)
                bank_mem[i] <= '0;
        end else if (wr_commit && wr_kind == SREG_KIND_BANK) begin
            bank_mem[wr_idx] <= wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            wr_fault <= 1'b0;
        else
            wr_fault <= wr_en && wr_in_space && !wr_legal;
    end

    sreg_counter #(.WIDTH(REG_WIDTH)) u_cycle (
        .clk      (clk),
        .rst      (rst),
        .inc      (1'b1),
        .load     (wr_commit && wr_kind == SREG_KIND_CYCLE),
        .load_val (wr_val),
        .count    (cycle_count)
    );

    sreg_counter #(.WIDTH(REG_WIDTH)) u_instret (
        .clk      (clk),
        .rst      (rst),
        .inc      (retire_valid),
        .load     (wr_commit && wr_kind == SREG_KIND_INSTRET),
        .load_val (wr_val),
        .count    (instret_count)
    );

    always_comb begin
        rd_stored = '0;
        case (rd_kind)
            SREG_KIND_CYCLE:   rd_stored = cycle_count;
            SREG_KIND_INSTRET: rd_stored = instret_count;
            SREG_KIND_BANK:    rd_stored = bank_mem[rd_idx];
            default:           rd_stored = '0;
        endcase
    end

    // Counter kinds already pin down a unique group-0 register, so only banked
    // targets need the full index (which includes plevel) to match.
    always_comb begin
        bypass = 1'b0;
        if (wr_commit && wr_kind == rd_kind)
            bypass = (rd_kind != SREG_KIND_BANK) || (wr_idx == rd_idx);
    end

    assign rd_fault = rd_in_space && !rd_legal;
    assign rd_val   = !rd_legal ? '0 : (bypass ? wr_val : rd_stored);

endmodule

// File: tb/tb_sreg_file.sv
// Directed bench for sreg_file: banking, bypass, privilege, counters, reset.
module tb_sreg_file;

    logic        clk;
    logic        rst;
    logic [1:0]  cur_plevel;
    logic        retire_valid;
    logic        wr_en;
    logic [4:0]  wr_group;
    logic [2:0]  wr_regnum;
    logic [1:0]  wr_plevel;
    logic [31:0] wr_val;
    logic [4:0]  rd_group;
    logic [2:0]  rd_regnum;
    logic [1:0]  rd_plevel;
    logic [31:0] rd_val;
    logic        rd_fault;
    logic        wr_fault;

    int n_cmp = 0;
    int n_mis = 0;

    sreg_file #(.REG_WIDTH(32), .NUM_GROUPS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cur_plevel   (cur_plevel),
        .retire_valid (retire_valid),
        .wr_en        (wr_en),
        .wr_group     (wr_group),
        .wr_regnum    (wr_regnum),
        .wr_plevel    (wr_plevel),
        .wr_val       (wr_val),
        .rd_group     (rd_group),
        .rd_regnum    (rd_regnum),
        .rd_plevel    (rd_plevel),
        .rd_val       (rd_val),
        .rd_fault     (rd_fault),
        .wr_fault     (wr_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input int g, input int r, input int p, input logic [31:0] v);
        wr_en     = en;
        wr_group  = 5'(g);
        wr_regnum = 3'(r);
        wr_plevel = 2'(p);
        wr_val    = v;
        #1;
    endtask

    task automatic set_rd(input int g, input int r, input int p);
        rd_group  = 5'(g);
        rd_regnum = 3'(r);
        rd_plevel = 2'(p);
        #1;
    endtask

    int rv_pat[5] = '{1, 0, 1, 1, 0};

    initial begin
        rst = 1'b1; cur_plevel = 2'd0; retire_valid = 1'b0;
        wr_en = 1'b0; wr_group = '0; wr_regnum = '0; wr_plevel = '0; wr_val = '0;
        rd_group = '0; rd_regnum = '0; rd_plevel = '0;
        step();
        step();
        rst = 1'b0;

        // Counters: CYCLE 0 in first cycle out of reset, then counts up.
        set_rd(0, 0, 0);
        check("cycle_after_reset", rd_val, 32'd0);
        check("rd_fault_reset", {31'd0, rd_fault}, 32'd0);
        check("wr_fault_reset", {31'd0, wr_fault}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            retire_valid = rv_pat[i][0];
            step();
            check($sformatf("cycle_%0d", i + 1), rd_val, 32'(i + 1));
        end
        retire_valid = 1'b0;
        set_rd(0, 1, 0);
        check("instret_3_of_5", rd_val, 32'd3);

        // Bank isolation.
        set_wr(1, 1, 3, 2, 32'hA5);
        step();
        set_wr(1, 1, 3, 1, 32'h5A);
        step();
        set_wr(0, 0, 0, 0, 32'h0);
        set_rd(1, 3, 2);
        check("bank_pl2", rd_val, 32'hA5);
        set_rd(1, 3, 1);
        check("bank_pl1", rd_val, 32'h5A);
        set_rd(1, 3, 0);
        check("bank_pl0", rd_val, 32'h0);

        // Read bypass, then the committed value from storage.
        set_rd(2, 7, 0);
        check("pre_bypass", rd_val, 32'h0);
        set_wr(1, 2, 7, 0, 32'h1234);
        check("bypass", rd_val, 32'h1234);
        step();
        set_wr(0, 0, 0, 0, 32'h0);
        check("after_bypass", rd_val, 32'h1234);

        // Privilege: denied write, one-cycle fault pulse.
        cur_plevel = 2'd2;
        set_wr(1, 1, 0, 1, 32'hFF);
        check("wr_fault_same_cycle", {31'd0, wr_fault}, 32'd0);
        step();
        set_wr(0, 0, 0, 0, 32'h0);
        check("wr_fault_pulse", {31'd0, wr_fault}, 32'd1);
        step();
        check("wr_fault_drop", {31'd0, wr_fault}, 32'd0);
        set_rd(1, 0, 1);
        check("priv_rd_fault", {31'd0, rd_fault}, 32'd1);
        check("priv_rd_val", rd_val, 32'h0);
        set_rd(1, 0, 3);
        check("priv_rd_ok", {31'd0, rd_fault}, 32'd0);
        cur_plevel = 2'd0;
        set_rd(1, 0, 1);
        check("denied_reg_unchanged", rd_val, 32'h0);

        // Back-to-back denied writes hold wr_fault high.
        cur_plevel = 2'd3;
        set_wr(1, 3, 2, 0, 32'h77);
        step();
        check("wr_fault_b2b_1", {31'd0, wr_fault}, 32'd1);
        step();
        check("wr_fault_b2b_2", {31'd0, wr_fault}, 32'd1);
        set_wr(0, 0, 0, 0, 32'h0);
        step();
        check("wr_fault_b2b_end", {31'd0, wr_fault}, 32'd0);
        cur_plevel = 2'd0;
        set_rd(3, 2, 0);
        check("b2b_reg_unchanged", rd_val, 32'h0);

        // CYCLE wrap from all-ones.
        set_rd(0, 0, 0);
        set_wr(1, 0, 0, 0, 32'hFFFF_FFFF);
        step();
        set_wr(0, 0, 0, 0, 32'h0);
        check("cycle_all_ones", rd_val, 32'hFFFF_FFFF);
        step();
        check("cycle_wrap", rd_val, 32'h0);

        // Load beats increment.
        set_rd(0, 1, 0);
        retire_valid = 1'b1;
        set_wr(1, 0, 1, 0, 32'd100);
        check("instret_bypass", rd_val, 32'd100);
        step();
        retire_valid = 1'b0;
        set_wr(0, 0, 0, 0, 32'h0);
        check("instret_load", rd_val, 32'd100);

        // Unimplemented group-0 slot and out-of-range group.
        set_rd(0, 5, 0);
        set_wr(1, 0, 5, 0, 32'h77);
        check("g0_unimpl_no_bypass", rd_val, 32'h0);
        step();
        set_wr(0, 0, 0, 0, 32'h0);
        check("g0_unimpl_rd", rd_val, 32'h0);
        check("g0_unimpl_nofault", {31'd0, wr_fault}, 32'd0);
        set_rd(4, 0, 0);
        set_wr(1, 4, 0, 0, 32'h55);
        check("oor_no_bypass", rd_val, 32'h0);
        step();
        set_wr(0, 0, 0, 0, 32'h0);
        check("oor_rd", rd_val, 32'h0);
        check("oor_nofault", {31'd0, wr_fault}, 32'd0);
        check("oor_rd_nofault", {31'd0, rd_fault}, 32'd0);

        // Reset overrides a write and a retire in the same cycle.
        set_wr(1, 1, 1, 0, 32'h1111);
        step();
        set_wr(0, 0, 0, 0, 32'h0);
        set_rd(1, 1, 0);
        check("pre_reset_val", rd_val, 32'h1111);
        rst = 1'b1;
        retire_valid = 1'b1;
        set_wr(1, 1, 1, 0, 32'h2222);
        step();
        rst = 1'b0;
        retire_valid = 1'b0;
        set_wr(0, 0, 0, 0, 32'h0);
        set_rd(1, 1, 0);
        check("reset_mid_write", rd_val, 32'h0);
        set_rd(1, 3, 2);
        check("reset_bank", rd_val, 32'h0);
        set_rd(0, 1, 0);
        check("reset_instret", rd_val, 32'h0);
        set_rd(0, 0, 0);
        check("reset_cycle", rd_val, 32'h0);
        step();
        check("reset_cycle_next", rd_val, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
